// File: rtl/age_issue_queue.sv
// age_issue_queue: age-ordered issue queue with payload storage, slot allocation and starvation override
// Ports:
//    clk, rstn          clock, asynchronous active-low reset
//    enq_vld_i          per-port enqueue request
//    enq_rdy_o          per-port free slot available (j-th lowest free slot)
//    enq_data_i         per-port payload
//    enq_ready_bit_i    per-port entry is issue-ready at enqueue
//    enq_idx_o          per-port allocated slot index
//    wake_mask_i        sets ready for addressed valid entries
//    iss_vld_o          per-slot issue valid
//    iss_rdy_i          per-slot downstream accept
//    iss_data_o         per-slot issued payload
//    iss_idx_o          per-slot issued entry index
//    flush_i            drop all entries, block enqueue/wake/issue this cycle
//    count_o            number of valid entries
module age_issue_queue #(
   parameter int EntryCount   = 8,
   parameter int EnqWidth     = 2,
   parameter int SelWidth     = 2,
   parameter int DataWidth    = 32,
   parameter int StarveThresh = 15,
   parameter int IdxWidth     = $clog2(EntryCount)
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [EnqWidth-1:0]           enq_vld_i,
   output logic [EnqWidth-1:0]           enq_rdy_o,
   input  logic [EnqWidth*DataWidth-1:0] enq_data_i,
   input  logic [EnqWidth-1:0]           enq_ready_bit_i,
   output logic [EnqWidth*IdxWidth-1:0]  enq_idx_o,
   input  logic [EntryCount-1:0]         wake_mask_i,
   output logic [SelWidth-1:0]           iss_vld_o,
   input  logic [SelWidth-1:0]           iss_rdy_i,
   output logic [SelWidth*DataWidth-1:0] iss_data_o,
   output logic [SelWidth*IdxWidth-1:0]  iss_idx_o,
   input  logic                          flush_i,
   output logic [IdxWidth:0]             count_o
);
   localparam int CntWidth  = $clog2(StarveThresh + 1);
   localparam int PortWidth = EnqWidth > 1 ? $clog2(EnqWidth) : 1;

   logic [EntryCount-1:0] valid, ready, valid_nxt, ready_nxt, enq_mask, fire_mask;
   logic [EntryCount-1:0] age [EntryCount];
   logic [EntryCount-1:0] age_nxt [EntryCount];
   logic [CntWidth-1:0]   wait_cnt [EntryCount];
   logic [CntWidth-1:0]   cnt_nxt [EntryCount];
   logic [DataWidth-1:0]  data [EntryCount];
   logic [PortWidth-1:0]  enq_port [EntryCount];
   logic [IdxWidth-1:0]   alloc_idx [EnqWidth];
   logic [EnqWidth-1:0]   alloc_ok, enq_fire;

   // Port j takes the j-th lowest free slot; readiness depends only on registered valid bits.
   always_comb begin
      logic [EntryCount-1:0] taken;
      taken = '0;
      enq_idx_o = '0;
      for (int j = 0; j < EnqWidth; j++) begin
         alloc_idx[j] = '0;
         alloc_ok[j] = 1'b0;
         for (int i = 0; i < EntryCount; i++)
            if (!valid[i] && !taken[i] && !alloc_ok[j]) begin
               alloc_idx[j] = IdxWidth'(i);
               alloc_ok[j] = 1'b1;
               taken[i] = 1'b1;
            end
         enq_idx_o[j*IdxWidth +: IdxWidth] = alloc_idx[j];
      end
   end

   assign enq_rdy_o = alloc_ok;
   assign enq_fire  = enq_vld_i & alloc_ok & {EnqWidth{~flush_i}};

   // Per-slot view of this cycle's enqueues: which slots fill and from which port.
   always_comb begin
      for (int i = 0; i < EntryCount; i++) begin
         enq_mask[i] = 1'b0;
         enq_port[i] = '0;
         for (int j = 0; j < EnqWidth; j++)
            if (enq_fire[j] && alloc_idx[j] == IdxWidth'(i)) begin
               enq_mask[i] = 1'b1;
               enq_port[i] = PortWidth'(j);
            end
      end
   end

   // Each slot takes the oldest starved candidate if any, else the oldest candidate,
   // then removes it from the pool seen by later slots.
   always_comb begin
      logic [EntryCount-1:0] avail, starved, pool;
      logic [IdxWidth-1:0]   pick;
      logic                  found, older;
      avail = valid & ready;
      for (int i = 0; i < EntryCount; i++)
         starved[i] = wait_cnt[i] == CntWidth'(StarveThresh);
      fire_mask = '0;
      iss_vld_o = '0;
      iss_idx_o = '0;
      iss_data_o = '0;
      for (int s = 0; s < SelWidth; s++) begin
         pool = |(avail & starved) ? avail & starved : avail;
         pick = '0;
         found = 1'b0;
         for (int r = 0; r < EntryCount; r++) begin
            older = 1'b0;
            for (int c = 0; c < EntryCount; c++)
               if (c != r && pool[c] && age[c][r]) older = 1'b1;
            if (pool[r] && !older && !found) begin
               pick = IdxWidth'(r);
               found = 1'b1;
               avail[r] = 1'b0;
               if (!flush_i && iss_rdy_i[s]) fire_mask[r] = 1'b1;
            end
         end
         iss_vld_o[s] = found & ~flush_i;
         iss_idx_o[s*IdxWidth +: IdxWidth] = pick;
         iss_data_o[s*DataWidth +: DataWidth] = data[pick];
      end
   end

   // A new entry is younger than all residents and lower-numbered ports' entries this cycle,
   // older than higher-numbered ports' entries; stale bits of free slots are rewritten on allocation.
   always_comb begin
      valid_nxt = flush_i ? '0 : (valid & ~fire_mask) | enq_mask;
      for (int i = 0; i < EntryCount; i++) begin
         ready_nxt[i] = enq_mask[i] ? enq_ready_bit_i[enq_port[i]]
                                    : ready[i] | (wake_mask_i[i] & valid[i] & ~flush_i);
         cnt_nxt[i] = enq_mask[i] ? '0
                    : (valid[i] && ready[i] && !fire_mask[i] && wait_cnt[i] != CntWidth'(StarveThresh))
                      ? wait_cnt[i] + CntWidth'(1) : wait_cnt[i];
         for (int c = 0; c < EntryCount; c++)
            age_nxt[i][c] = enq_mask[c] ? (enq_mask[i] ? enq_port[i] < enq_port[c] : valid[i])
                          : enq_mask[i] ? 1'b0 : age[i][c];
      end
   end

   always_comb begin
      count_o = '0;
      for (int i = 0; i < EntryCount; i++)
         count_o = count_o + (IdxWidth+1)'(valid[i]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid <= '0;
         ready <= '0;
         for (int i = 0; i < EntryCount; i++) begin
            wait_cnt[i] <= '0;
            age[i] <= '0;
         end
      end else begin
         valid <= valid_nxt;
         ready <= ready_nxt;
         for (int i = 0; i < EntryCount; i++) begin
            wait_cnt[i] <= cnt_nxt[i];
            age[i] <= age_nxt[i];
         end
      end
   end

   // Payload needs no reset: it is only observed while the entry is valid.
   always_ff @(posedge clk)
      for (int i = 0; i < EntryCount; i++)
         if (enq_mask[i]) data[i] <= enq_data_i[enq_port[i]*DataWidth +: DataWidth];
endmodule

// File: tb/tb_age_issue_queue.sv
// tb_age_issue_queue: directed table-driven checks plus starvation sequences for age_issue_queue
module tb_age_issue_queue;
   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  enq_vld_i, enq_rdy_o, enq_ready_bit_i, iss_vld_o, iss_rdy_i;
   logic [63:0] enq_data_i, iss_data_o;
   logic [5:0]  enq_idx_o, iss_idx_o;
   logic [7:0]  wake_mask_i;
   logic        flush_i;
   logic [3:0]  count_o;
   int          errors = 0;
   int          checks = 0;

   age_issue_queue dut (
      .clk(clk), .rstn(rstn),
      .enq_vld_i(enq_vld_i), .enq_rdy_o(enq_rdy_o), .enq_data_i(enq_data_i),
      .enq_ready_bit_i(enq_ready_bit_i), .enq_idx_o(enq_idx_o), .wake_mask_i(wake_mask_i),
      .iss_vld_o(iss_vld_o), .iss_rdy_i(iss_rdy_i), .iss_data_o(iss_data_o),
      .iss_idx_o(iss_idx_o), .flush_i(flush_i), .count_o(count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] ev, erb;
      logic [7:0] t0, t1, wake;
      logic [1:0] ir;
      logic       fl;
      logic [1:0] x_er;
      logic [2:0] x_ei0, x_ei1;
      logic [1:0] x_iv;
      logic [2:0] x_ii0, x_ii1;
      logic [7:0] x_it0, x_it1;
      logic [3:0] x_cnt;
   } vec_t;

   vec_t vecs [20];

   function automatic vec_t mk(logic [1:0] ev, logic [1:0] erb, logic [7:0] t0, logic [7:0] t1,
                               logic [7:0] wake, logic [1:0] ir, logic fl,
                               logic [1:0] x_er, logic [2:0] x_ei0, logic [2:0] x_ei1,
                               logic [1:0] x_iv, logic [2:0] x_ii0, logic [2:0] x_ii1,
                               logic [7:0] x_it0, logic [7:0] x_it1, logic [3:0] x_cnt);
      vec_t v;
      v.ev = ev; v.erb = erb; v.t0 = t0; v.t1 = t1; v.wake = wake; v.ir = ir; v.fl = fl;
      v.x_er = x_er; v.x_ei0 = x_ei0; v.x_ei1 = x_ei1; v.x_iv = x_iv;
      v.x_ii0 = x_ii0; v.x_ii1 = x_ii1; v.x_it0 = x_it0; v.x_it1 = x_it1; v.x_cnt = x_cnt;
      return v;
   endfunction

   function automatic logic [31:0] pl(logic [7:0] tag);
      return {24'h5A5A5A, tag};
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (step %0d): got %0h expected %0h", nm, k, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] ev, input logic [1:0] erb, input logic [7:0] t0,
                        input logic [7:0] t1, input logic [7:0] wake, input logic [1:0] ir,
                        input logic fl);
      enq_vld_i = ev;
      enq_ready_bit_i = erb;
      enq_data_i = {pl(t1), pl(t0)};
      wake_mask_i = wake;
      iss_rdy_i = ir;
      flush_i = fl;
      @(negedge clk);
   endtask

   task automatic adv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rst_count", -1, 32'(count_o), 0);
      chk("rst_iss_vld", -1, 32'(iss_vld_o), 0);
      chk("rst_enq_rdy", -1, 32'(enq_rdy_o), 2'b11);
      adv();
      rstn = 1'b1;

      //            ev erb  t0     t1     wake   ir fl | er ei0 ei1 iv ii0 ii1 it0    it1    cnt
      vecs[0]  = mk(0, 0,   8'h00, 8'h00, 8'h00, 0, 0,   3, 0,  1,  0, 0,  0,  8'h00, 8'h00, 0);
      vecs[1]  = mk(3, 3,   8'hA1, 8'hB2, 8'h00, 0, 0,   3, 0,  1,  0, 0,  0,  8'h00, 8'h00, 0);
      vecs[2]  = mk(1, 1,   8'hC3, 8'h00, 8'h00, 3, 0,   3, 2,  3,  3, 0,  1,  8'hA1, 8'hB2, 2);
      vecs[3]  = mk(0, 0,   8'h00, 8'h00, 8'h00, 3, 0,   3, 0,  1,  1, 2,  0,  8'hC3, 8'h00, 1);
      vecs[4]  = mk(0, 0,   8'h00, 8'h00, 8'h00, 0, 0,   3, 0,  1,  0, 0,  0,  8'h00, 8'h00, 0);
      vecs[5]  = mk(3, 2,   8'hA4, 8'hB5, 8'h00, 1, 0,   3, 0,  1,  0, 0,  0,  8'h00, 8'h00, 0);
      vecs[6]  = mk(0, 0,   8'h00, 8'h00, 8'h00, 1, 0,   3, 2,  3,  1, 1,  0,  8'hB5, 8'h00, 2);
      vecs[7]  = mk(0, 0,   8'h00, 8'h00, 8'h01, 1, 0,   3, 1,  2,  0, 0,  0,  8'h00, 8'h00, 1);
      vecs[8]  = mk(0, 0,   8'h00, 8'h00, 8'h00, 1, 0,   3, 1,  2,  1, 0,  0,  8'hA4, 8'h00, 1);
      vecs[9]  = mk(3, 0,   8'h10, 8'h11, 8'h00, 0, 0,   3, 0,  1,  0, 0,  0,  8'h00, 8'h00, 0);
      vecs[10] = mk(3, 0,   8'h12, 8'h13, 8'h00, 0, 0,   3, 2,  3,  0, 0,  0,  8'h00, 8'h00, 2);
      vecs[11] = mk(3, 0,   8'h14, 8'h15, 8'h00, 0, 0,   3, 4,  5,  0, 0,  0,  8'h00, 8'h00, 4);
      vecs[12] = mk(3, 0,   8'h16, 8'h17, 8'h00, 0, 0,   3, 6,  7,  0, 0,  0,  8'h00, 8'h00, 6);
      vecs[13] = mk(0, 0,   8'h00, 8'h00, 8'h08, 0, 0,   0, 0,  0,  0, 0,  0,  8'h00, 8'h00, 8);
      vecs[14] = mk(0, 0,   8'h00, 8'h00, 8'h00, 1, 0,   0, 0,  0,  1, 3,  0,  8'h13, 8'h00, 8);
      vecs[15] = mk(0, 0,   8'h00, 8'h00, 8'h60, 0, 0,   1, 3,  0,  0, 0,  0,  8'h00, 8'h00, 7);
      vecs[16] = mk(1, 1,   8'h18, 8'h00, 8'h00, 3, 0,   1, 3,  0,  3, 5,  6,  8'h15, 8'h16, 7);
      vecs[17] = mk(0, 0,   8'h00, 8'h00, 8'h00, 0, 0,   3, 5,  6,  1, 3,  0,  8'h18, 8'h00, 6);
      vecs[18] = mk(3, 3,   8'h20, 8'h21, 8'h00, 3, 1,   3, 5,  6,  0, 0,  0,  8'h00, 8'h00, 6);
      vecs[19] = mk(0, 0,   8'h00, 8'h00, 8'h00, 0, 0,   3, 0,  1,  0, 0,  0,  8'h00, 8'h00, 0);

      for (int k = 0; k < 20; k++) begin
         drive(vecs[k].ev, vecs[k].erb, vecs[k].t0, vecs[k].t1, vecs[k].wake, vecs[k].ir, vecs[k].fl);
         chk("enq_rdy", k, 32'(enq_rdy_o), 32'(vecs[k].x_er));
         if (vecs[k].x_er[0]) chk("enq_idx0", k, 32'(enq_idx_o[2:0]), 32'(vecs[k].x_ei0));
         if (vecs[k].x_er[1]) chk("enq_idx1", k, 32'(enq_idx_o[5:3]), 32'(vecs[k].x_ei1));
         chk("iss_vld", k, 32'(iss_vld_o), 32'(vecs[k].x_iv));
         if (vecs[k].x_iv[0]) begin
            chk("iss_idx0", k, 32'(iss_idx_o[2:0]), 32'(vecs[k].x_ii0));
            chk("iss_data0", k, iss_data_o[31:0], pl(vecs[k].x_it0));
         end
         if (vecs[k].x_iv[1]) begin
            chk("iss_idx1", k, 32'(iss_idx_o[5:3]), 32'(vecs[k].x_ii1));
            chk("iss_data1", k, iss_data_o[63:32], pl(vecs[k].x_it1));
         end
         chk("count", k, 32'(count_o), 32'(vecs[k].x_cnt));
         adv();
      end

      // Both old and young entries saturate together; the older one still wins slot 0.
      drive(3, 3, 8'h30, 8'h31, 0, 0, 0);
      chk("sa_enq_rdy", 100, 32'(enq_rdy_o), 2'b11);
      adv();
      repeat (15) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         adv();
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("sa_iss_vld", 101, 32'(iss_vld_o), 2'b11);
      chk("sa_iss_idx0", 101, 32'(iss_idx_o[2:0]), 0);
      chk("sa_iss_data0", 101, iss_data_o[31:0], pl(8'h30));
      chk("sa_iss_idx1", 101, 32'(iss_idx_o[5:3]), 1);
      adv();
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("sa_iss_vld2", 102, 32'(iss_vld_o), 2'b01);
      chk("sa_iss_idx2", 102, 32'(iss_idx_o[2:0]), 1);
      chk("sa_count", 102, 32'(count_o), 1);
      adv();

      // A starved younger entry overtakes a freshly woken older entry.
      drive(1, 0, 8'h40, 0, 0, 0, 0);
      chk("sb_enq_idx_o", 200, 32'(enq_idx_o[2:0]), 0);
      adv();
      drive(1, 1, 8'h41, 0, 0, 0, 0);
      chk("sb_enq_idx_y", 201, 32'(enq_idx_o[2:0]), 1);
      adv();
      repeat (15) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         adv();
      end
      drive(0, 0, 0, 0, 8'h01, 0, 0);
      chk("sb_pre_wake_vld", 202, 32'(iss_vld_o), 2'b01);
      chk("sb_pre_wake_idx", 202, 32'(iss_idx_o[2:0]), 1);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("sb_iss_vld", 203, 32'(iss_vld_o), 2'b11);
      chk("sb_starved_idx0", 203, 32'(iss_idx_o[2:0]), 1);
      chk("sb_starved_data0", 203, iss_data_o[31:0], pl(8'h41));
      chk("sb_old_idx1", 203, 32'(iss_idx_o[5:3]), 0);
      chk("sb_count", 203, 32'(count_o), 2);
      adv();
      drive(0, 0, 0, 0, 0, 0, 1);
      chk("sb_flush_vld", 204, 32'(iss_vld_o), 0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("sb_flush_count", 205, 32'(count_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
